// File: rtl/smiley_move_if.sv
// smiley_move_if: frame-timing, collision and position signals between the smiley motion stage and its neighbours.
// Latency: none; this is wiring only.
// Backpressure: none; every signal is sampled or driven once per clock.
// Ports: master drives startOfFrame, collision, HitEdgeCode {Left,Top,Right,Bottom} and freeze, and reads topLeftX/topLeftY.
//        slave (the motion stage) reads those inputs and drives topLeftX/topLeftY as signed 11-bit pixel coordinates.
interface smiley_move_if;
    logic               startOfFrame;
    logic               collision;
    logic [3:0]         HitEdgeCode;
    logic               freeze;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;

    modport master (
        output startOfFrame,
        output collision,
        output HitEdgeCode,
        output freeze,
        input  topLeftX,
        input  topLeftY
    );

    modport slave (
        input  startOfFrame,
        input  collision,
        input  HitEdgeCode,
        input  freeze,
        output topLeftX,
        output topLeftY
    );
endinterface

// File: rtl/smiley_move.sv
// smiley_move: per-frame fixed-point motion of the smiley object (gravity, edge bounce, screen clamp).
// Latency: topLeftX/topLeftY update 2 clocks after the startOfFrame that closes a frame, then hold.
// Backpressure: none; freeze holds motion, and startOfFrame during the two update cycles is ignored.
// Ports: clk; reset (synchronous, active-high); bus (slave modport) carrying startOfFrame, collision,
//        HitEdgeCode {Left,Top,Right,Bottom} and freeze in, and topLeftX/topLeftY (signed 11-bit pixels) out.
module smiley_move #(
    parameter int INITIAL_X              = 280,
    parameter int INITIAL_Y              = 185,
    parameter int INITIAL_X_SPEED        = 40,
    parameter int INITIAL_Y_SPEED        = 20,
    parameter int Y_ACCEL                = 1,
    parameter int MAX_Y_SPEED            = 230,
    parameter int FIXED_POINT_MULTIPLIER = 64,
    parameter int OBJECT_SIZE            = 32
) (
    input  logic         clk,
    input  logic         reset,
    smiley_move_if.slave bus
);

    // Position and speed share one fixed-point scale; the multiplier is a power of two,
    // so converting back to pixels is an arithmetic right shift.
    localparam int FP_SHIFT = $clog2(FIXED_POINT_MULTIPLIER);

    localparam logic signed [31:0] X_INIT    = 32'(INITIAL_X * FIXED_POINT_MULTIPLIER);
    localparam logic signed [31:0] Y_INIT    = 32'(INITIAL_Y * FIXED_POINT_MULTIPLIER);
    localparam logic signed [31:0] XSPD_INIT = 32'(INITIAL_X_SPEED);
    localparam logic signed [31:0] YSPD_INIT = 32'(INITIAL_Y_SPEED);
    localparam logic signed [31:0] Y_ACC     = 32'(Y_ACCEL);
    localparam logic signed [31:0] Y_SPD_MAX = 32'(MAX_Y_SPEED);

    // The top-left corner may not go below zero, or so far right/down that the object leaves the 640x480 screen.
    localparam logic signed [31:0] X_MAX = 32'((640 - OBJECT_SIZE) * FIXED_POINT_MULTIPLIER);
    localparam logic signed [31:0] Y_MAX = 32'((480 - OBJECT_SIZE) * FIXED_POINT_MULTIPLIER);

    // Bit positions within HitEdgeCode.
    localparam int HIT_L = 3;
    localparam int HIT_T = 2;
    localparam int HIT_R = 1;
    localparam int HIT_B = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MOVE  = 2'd1,
        S_SPEED = 2'd2,
        S_POS   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic signed [31:0] x_pos_q, x_pos_d;
    logic signed [31:0] y_pos_q, y_pos_d;
    logic signed [31:0] x_spd_q, x_spd_d;
    logic signed [31:0] y_spd_q, y_spd_d;
    logic [3:0]         hit_q,   hit_d;

    // Intermediate results of the speed and position updates.
    logic signed [31:0] x_bnc;
    logic signed [31:0] y_bnc;
    logic signed [31:0] y_acc;
    logic signed [31:0] x_sum;
    logic signed [31:0] y_sum;

    function automatic logic signed [31:0] abs_s(input logic signed [31:0] v);
        return (v < 0) ? -v : v;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a frozen frame stays in S_MOVE.
    // S_SPEED and S_POS always run to completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.startOfFrame) state_d = S_MOVE;
            S_MOVE:  if (bus.startOfFrame && !bus.freeze) state_d = S_SPEED;
            S_SPEED: state_d = S_POS;
            S_POS:   state_d = S_MOVE;
            default: state_d = S_IDLE;
        endcase
    end

    // Per-state datapath.
    // The speed update (bounce, then gravity) runs one cycle before the position update,
    // so the new position always uses this frame's speed.
    always_comb begin
        x_pos_d = x_pos_q;
        y_pos_d = y_pos_q;
        x_spd_d = x_spd_q;
        y_spd_d = y_spd_q;
        hit_d   = hit_q;
        x_bnc   = x_spd_q;
        y_bnc   = y_spd_q;
        y_acc   = y_spd_q;
        x_sum   = x_pos_q;
        y_sum   = y_pos_q;

        case (state_q)
            S_MOVE: begin
                // A collision on the closing startOfFrame cycle still counts for this frame.
                if (bus.collision) begin
                    hit_d = hit_q | bus.HitEdgeCode;
                end
                // A frozen frame discards everything it collected, including that last cycle.
                if (bus.startOfFrame && bus.freeze) begin
                    hit_d = '0;
                end
            end

            S_SPEED: begin
                // Both hit bits are judged against the speed at the start of the frame.
                // A hit on the edge the object is moving away from changes nothing.
                if ((hit_q[HIT_L] && (x_spd_q < 0)) || (hit_q[HIT_R] && (x_spd_q > 0))) begin
                    x_bnc = -x_spd_q;
                end
                if ((hit_q[HIT_T] && (y_spd_q < 0)) || (hit_q[HIT_B] && (y_spd_q > 0))) begin
                    y_bnc = -y_spd_q;
                end
                // Gravity only ever adds downward speed, so only the positive side needs a limit.
                y_acc   = y_bnc + Y_ACC;
                x_spd_d = x_bnc;
                y_spd_d = (y_acc > Y_SPD_MAX) ? Y_SPD_MAX : y_acc;
                hit_d   = '0;
            end

            S_POS: begin
                x_sum = x_pos_q + x_spd_q;
                y_sum = y_pos_q + y_spd_q;

                // When the object is clamped to the screen, its speed is pointed back into the screen.
                if (x_sum < 0) begin
                    x_pos_d = '0;
                    x_spd_d = abs_s(x_spd_q);
                end else if (x_sum > X_MAX) begin
                    x_pos_d = X_MAX;
                    x_spd_d = -abs_s(x_spd_q);
                end else begin
                    x_pos_d = x_sum;
                end

                if (y_sum < 0) begin
                    y_pos_d = '0;
                    y_spd_d = abs_s(y_spd_q);
                end else if (y_sum > Y_MAX) begin
                    y_pos_d = Y_MAX;
                    y_spd_d = -abs_s(y_spd_q);
                end else begin
                    y_pos_d = y_sum;
                end
            end

            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_pos_q <= X_INIT;
            y_pos_q <= Y_INIT;
            x_spd_q <= XSPD_INIT;
            y_spd_q <= YSPD_INIT;
            hit_q   <= '0;
        end else begin
            x_pos_q <= x_pos_d;
            y_pos_q <= y_pos_d;
            x_spd_q <= x_spd_d;
            y_spd_q <= y_spd_d;
            hit_q   <= hit_d;
        end
    end

    // The outputs come straight from the position registers.
    // They change only on the clock edge that leaves S_POS, and hold for the rest of the frame.
    assign bus.topLeftX = 11'(x_pos_q >>> FP_SHIFT);
    assign bus.topLeftY = 11'(y_pos_q >>> FP_SHIFT);

endmodule
